// File: rtl/lcd_signal_pager.sv
// Pages N_CH two-bit semaphore lamp states onto a 2x16 LCD, two channels
// per page, streaming one character per valid/ready beat.
module lcd_signal_pager #(
   parameter int N_CH = 4,
   parameter int PAGE_CYCLES = 50000000,
   localparam int N_PAGES = (N_CH + 1) / 2,
   localparam int PW = (N_PAGES > 1) ? $clog2(N_PAGES) : 1,
   localparam int CW = $clog2(PAGE_CYCLES)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [2*N_CH-1:0] S,
   output logic [7:0]        CHAR_DATA,
   output logic [4:0]        CHAR_ADDR,
   output logic              CHAR_VALID,
   input  logic              CHAR_READY,
   output logic [PW-1:0]     PAGE,
   output logic              BUSY,
   output logic              FRAME_DONE
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt;
   logic [3:0]          snap;
   logic [2*N_CH+1:0]   s_pad;
   logic [1:0]          live0, live1, st;
   logic                line1_on, changed, expire, xfer;
   logic [7:0]          glyph;
   int                  c0;

   function automatic logic [7:0] word_char(input logic [1:0] code, input int i);
      logic [63:0] w;
      unique case (code)
         2'b01:   w = "VERDE   ";
         2'b10:   w = "LARANJA ";
         2'b11:   w = "VERMELHO";
         default: w = "APAGADO ";
      endcase
      return (i < 8) ? w[8*(7-i) +: 8] : 8'd32;
   endfunction

   // A missing odd tail channel reads as the zero pad, so it never differs.
   always_comb begin
      s_pad    = {2'b00, S};
      c0       = 2 * int'(PAGE);
      live0    = s_pad[2*c0 +: 2];
      live1    = s_pad[2*c0+2 +: 2];
      line1_on = (c0 + 1) < N_CH;
      changed  = (live0 != snap[1:0]) || (live1 != snap[3:2]);
      expire   = (N_PAGES > 1) && (cnt == CW'(PAGE_CYCLES - 1));
      xfer     = CHAR_VALID && CHAR_READY;
   end

   always_comb begin
      st    = CHAR_ADDR[4] ? snap[3:2] : snap[1:0];
      glyph = 8'd32;
      unique case (CHAR_ADDR[3:0])
         4'd0:    glyph = "S";
         4'd1:    glyph = 8'd49 + 8'(c0) + 8'(CHAR_ADDR[4]);
         4'd2:    glyph = ":";
         4'd3:    glyph = 8'd32;
         default: glyph = word_char(st, int'(CHAR_ADDR[3:0]) - 4);
      endcase
      if (CHAR_ADDR[4] && !line1_on) glyph = 8'd32;
      CHAR_DATA = CHAR_VALID ? glyph : 8'd32;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (expire || changed) state_n = LOAD;
         LOAD:    state_n = SEND;
         SEND:    if (xfer && CHAR_ADDR == 5'd31) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Reset lands directly in LOAD so page 0 renders without a trigger.
   always_ff @(posedge CLK) begin
      if (RST) state <= LOAD;
      else     state <= state_n;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         CHAR_VALID <= 1'b0;
         CHAR_ADDR  <= '0;
         PAGE       <= '0;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
         cnt        <= '0;
         snap       <= '0;
      end else begin
         FRAME_DONE <= 1'b0;
         unique case (state)
            IDLE: begin
               if (expire) begin
                  PAGE <= (PAGE == PW'(N_PAGES - 1)) ? '0 : PAGE + PW'(1);
                  cnt  <= '0;
               end else if (N_PAGES > 1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            LOAD: begin
               snap       <= {live1, live0};
               CHAR_ADDR  <= '0;
               BUSY       <= 1'b1;
               CHAR_VALID <= 1'b1;
            end
            SEND: begin
               if (xfer) begin
                  CHAR_ADDR <= CHAR_ADDR + 5'd1;
                  if (CHAR_ADDR == 5'd31) begin
                     CHAR_VALID <= 1'b0;
                     BUSY       <= 1'b0;
                     FRAME_DONE <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_signal_pager.sv
// Directed bench for lcd_signal_pager: three channels, short dwell,
// frames captured beat by beat and compared against literal LCD lines.
module tb_lcd_signal_pager;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] S = 6'b11_10_01;
   logic       CHAR_READY = 1'b1;
   logic [7:0] CHAR_DATA;
   logic [4:0] CHAR_ADDR;
   logic       CHAR_VALID;
   logic [0:0] PAGE;
   logic       BUSY;
   logic       FRAME_DONE;

   lcd_signal_pager #(.N_CH(3), .PAGE_CYCLES(100)) dut (
      .CLK(CLK), .RST(RST), .S(S),
      .CHAR_DATA(CHAR_DATA), .CHAR_ADDR(CHAR_ADDR),
      .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
      .PAGE(PAGE), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] fr [32];
   int nx, order_err, stall_err, wait_n, len_n, k;
   bit tmo, busy0;
   logic [127:0] ref0, ref1;

   task automatic check(input string tag, input logic [127:0] got, exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [127:0] line_of(input int base);
      logic [127:0] v = '0;
      for (int i = 0; i < 16; i++) v = {v[119:0], fr[base+i]};
      return v;
   endfunction

   task automatic grab(input bit bp, input int chg_at, input logic [5:0] chg_s);
      bit prev_stall = 1'b0;
      logic [4:0] pa = '0;
      logic [7:0] pd = '0;
      nx = 0; order_err = 0; stall_err = 0;
      wait_n = 0; len_n = 0; tmo = 1'b0;
      for (int i = 0; i < 32; i++) fr[i] = 8'h00;
      CHAR_READY = 1'b1;
      do begin
         tick();
         wait_n++;
      end while (!CHAR_VALID && wait_n < 300);
      tmo = !CHAR_VALID;
      busy0 = BUSY;
      while (!tmo && !FRAME_DONE && len_n < 600) begin
         if (prev_stall && (!CHAR_VALID || CHAR_ADDR != pa || CHAR_DATA != pd))
            stall_err++;
         CHAR_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (CHAR_VALID && CHAR_READY) begin
            if (CHAR_ADDR != 5'(nx)) order_err++;
            fr[CHAR_ADDR] = CHAR_DATA;
            nx++;
            if (int'(CHAR_ADDR) == chg_at) S = chg_s;
         end
         prev_stall = CHAR_VALID && !CHAR_READY;
         pa = CHAR_ADDR;
         pd = CHAR_DATA;
         tick();
         len_n++;
      end
      if (!FRAME_DONE) tmo = 1'b1;
      CHAR_READY = 1'b1;
      check("frame_tmo", tmo, 0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_valid", CHAR_VALID, 0);
      check("rst_addr", CHAR_ADDR, 0);
      check("rst_data", CHAR_DATA, 32);
      check("rst_page", PAGE, 0);
      check("rst_busy", BUSY, 0);
      check("rst_fd", FRAME_DONE, 0);

      RST = 1'b0;
      grab(1'b0, -1, 6'b0);
      check("t1_wait", wait_n, 1);
      check("t1_busy", busy0, 1);
      check("t1_len", len_n, 32);
      check("t1_count", nx, 32);
      check("t1_order", order_err, 0);
      check("t1_line0", line_of(0), "S1: VERDE       ");
      check("t1_line1", line_of(16), "S2: LARANJA     ");
      check("t1_page", PAGE, 0);
      tick();
      check("t1_fd_pulse", FRAME_DONE, 0);
      check("t1_busy_off", BUSY, 0);

      grab(1'b0, -1, 6'b0);
      check("t2_wait", wait_n, 101);
      check("t2_page", PAGE, 1);
      check("t2_line0", line_of(0), "S3: VERMELHO    ");
      check("t2_line1", line_of(16), "                ");
      ref0 = line_of(0);
      ref1 = line_of(16);
      tick();
      grab(1'b0, -1, 6'b0);
      check("t2_wrap_wait", wait_n, 101);
      check("t2_wrap_page", PAGE, 0);
      check("t2_wrap_line0", line_of(0), "S1: VERDE       ");
      tick();

      grab(1'b1, -1, 6'b0);
      check("t3_count", nx, 32);
      check("t3_order", order_err, 0);
      check("t3_stable", stall_err, 0);
      check("t3_page", PAGE, 1);
      check("t3_line0", line_of(0), ref0);
      check("t3_line1", line_of(16), ref1);
      tick();
      grab(1'b0, -1, 6'b0);
      check("t3_back_page", PAGE, 0);

      tick();
      S = 6'b11_10_00;
      grab(1'b0, -1, 6'b0);
      check("t4_wait", wait_n, 2);
      check("t4_line0", line_of(0), "S1: APAGADO     ");
      check("t4_line1", line_of(16), "S2: LARANJA     ");
      check("t4_page", PAGE, 0);
      tick();
      S = 6'b01_10_00;
      k = 0;
      repeat (50) begin
         tick();
         if (CHAR_VALID) k++;
      end
      check("t4_hidden_quiet", k, 0);

      S = 6'b01_10_01;
      grab(1'b0, 10, 6'b01_11_01);
      check("t5_wait", wait_n, 2);
      check("t5_old_line0", line_of(0), "S1: VERDE       ");
      check("t5_old_line1", line_of(16), "S2: LARANJA     ");
      tick();
      check("t5_fd_pulse", FRAME_DONE, 0);
      grab(1'b0, -1, 6'b0);
      check("t5_rerender_wait", wait_n, 2);
      check("t5_new_line1", line_of(16), "S2: VERMELHO    ");
      check("t5_new_line0", line_of(0), "S1: VERDE       ");
      tick();
      k = 0;
      repeat (30) begin
         tick();
         if (CHAR_VALID) k++;
      end
      check("t5_once", k, 0);

      k = 0;
      do begin
         tick();
         k++;
      end while (!(CHAR_VALID && CHAR_ADDR == 5'd20) && k < 300);
      check("t6_reach", CHAR_VALID && CHAR_ADDR == 5'd20, 1);
      check("t6_page_pre", PAGE, 1);
      RST = 1'b1;
      tick();
      check("t6_valid", CHAR_VALID, 0);
      check("t6_page", PAGE, 0);
      check("t6_busy", BUSY, 0);
      check("t6_addr", CHAR_ADDR, 0);
      RST = 1'b0;
      grab(1'b0, -1, 6'b0);
      check("t6_wait", wait_n, 1);
      check("t6_count", nx, 32);
      check("t6_order", order_err, 0);
      check("t6_len", len_n, 32);
      check("t6_line0", line_of(0), "S1: VERDE       ");
      check("t6_line1", line_of(16), "S2: VERMELHO    ");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_signal_pager.md
Name: lcd_signal_pager

Overview:
- Parametrised successor to the two-channel traffic-signal LCD text mapper.
- Renders the 2-bit lamp state of N_CH semaphore channels into a 2x16 LCD character stream, two channels per page.
- Rotates pages on a dwell timer and re-renders the current page when any displayed channel changes.
- Streams characters one per valid/ready handshake to the downstream LCD controller.

Parameters:
- N_CH, 4, channel count; legal range 1..9, one ASCII digit per channel label.
- PAGE_CYCLES, 50000000, IDLE cycles a page is held before advancing; minimum 2.
- N_PAGES, (N_CH+1)/2, derived; not overridable.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- S  in  2*N_CH  channel states; channel k (0-based) is S[2k+1:2k]. Encoding: 00 off, 01 green, 10 orange, 11 red.
- CHAR_DATA  out  8  ASCII character.
- CHAR_ADDR  out  5  LCD cell: 0..15 line 0, 16..31 line 1.
- CHAR_VALID  out  1  CHAR_DATA/CHAR_ADDR valid.
- CHAR_READY  in  1  downstream accepts the character.
- PAGE  out  max(1,clog2(N_PAGES))  current page index.
- BUSY  out  1  high while a frame is being sent.
- FRAME_DONE  out  1  one-cycle pulse after the last character of a frame is accepted.

Behaviour:
- Reset values: CHAR_VALID 0, CHAR_ADDR 0, CHAR_DATA 8'd32, PAGE 0, BUSY 0, FRAME_DONE 0, dwell counter 0, snapshot 0. FSM enters LOAD in the first cycle after RST falls, so page 0 renders without waiting for a change.
- FSM states: IDLE, LOAD, SEND, DONE.
- LOAD (1 cycle):
  - Snapshot the states of the page's channels: line 0 is channel 2*PAGE, line 1 is channel 2*PAGE+1.
  - Set CHAR_ADDR 0 and BUSY 1, then go to SEND.
- SEND:
  - CHAR_VALID 1. A transfer occurs on any cycle with CHAR_VALID && CHAR_READY.
  - While VALID && !READY, CHAR_DATA and CHAR_ADDR hold stable.
  - After a transfer, CHAR_ADDR increments and the next character is presented the following cycle; VALID stays high, so there are no bubbles.
  - The transfer at address 31 moves the FSM to DONE.
- DONE (1 cycle): CHAR_VALID 0, BUSY 0, FRAME_DONE 1, then IDLE.
- Line format, 16 cells:
  - 'S', ASCII digit of (channel+1), ':', ' '.
  - Then the colour word: 01 VERDE, 10 LARANJA, 11 VERMELHO, 00 APAGADO.
  - Right-pad with 8'd32 to 16 cells.
  - Characters come from the snapshot, never from live S, so a frame is always coherent.
- Odd N_CH: line 1 of the last page is 16 spaces.
- IDLE, evaluated in this priority order:
  1. Dwell expiry: the dwell counter increments each IDLE cycle. When it reaches PAGE_CYCLES-1 and N_PAGES>1, set PAGE to (PAGE+1) mod N_PAGES (wrapping N_PAGES-1 to 0), clear the counter, and go to LOAD.
  2. Change detection: if live S of either displayed channel differs from the snapshot, go to LOAD. The counter is not cleared; PAGE is unchanged.
- N_PAGES==1: the counter is held at 0 and pages never advance.
- The counter does not count during LOAD, SEND or DONE.
- Changes on S during LOAD, SEND or DONE are not acted on mid-frame. They are caught by the IDLE comparison on the first IDLE cycle, causing exactly one re-render.
- Simultaneous dwell expiry and change: the page advance wins. The new page takes a fresh snapshot, with no extra render of the old page.
- Changes on non-displayed channels cause no render.
- RST mid-frame: the next cycle has CHAR_VALID 0 and all reset values, and the partial frame is abandoned. Rendering restarts at page 0, address 0.
- Latency with CHAR_READY tied high:
  - VALID at address 0 appears 2 cycles after the IDLE trigger cycle (trigger, LOAD, SEND).
  - A frame is 32 SEND cycles.
  - FRAME_DONE appears 1 cycle after the address-31 transfer.

Test Plan:
- Reset render: N_CH=3, PAGE_CYCLES=100, S=6'b11_10_01, READY=1, release RST.
  - Expect 32 transfers, addresses 0..31 in order.
  - Line 0 reads "S1: VERDE" plus 7 spaces; line 1 reads "S2: LARANJA" plus 5 spaces.
  - FRAME_DONE pulses once; PAGE=0.
- Page rotation and odd tail: same setup, wait for dwell.
  - PAGE becomes 1; line 0 reads "S3: VERMELHO"; addresses 16..31 are all 8'd32.
  - Next dwell: PAGE wraps to 0.
- Back-pressure: toggle CHAR_READY pseudo-randomly.
  - DATA/ADDR stay stable while VALID && !READY.
  - Exactly 32 accepted characters with no skips or duplicates.
  - The bench-captured frame matches the READY=1 frame.
- Change detection: in IDLE on page 0, set channel 0 to 00.
  - Re-render with line 0 "S1: APAGADO" plus 5 spaces; PAGE unchanged.
  - Changing channel 2 while on page 0 produces no frame.
- Mid-frame change: change channel 1 to 11 at address 10 of a frame.
  - The current frame completes with old text.
  - Exactly one following frame shows "S2: VERMELHO".
- Reset mid-frame: assert RST at address 20.
  - Next cycle: VALID 0, PAGE 0, BUSY 0.
  - After release, a full frame restarts from address 0.
